// File: rtl/des_sbox_bank.sv
// rtl/des_sbox_bank.sv - pipelined bank of DES S-boxes with valid/ready flow control
// Optional transfer counter (stats_clr/xfer_count) is built when DES_SBOX_STATS_EN is defined.
module des_sbox_bank #(
    parameter int FIRST_BOX  = 1,
    parameter int NUM_BOX    = 8,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:6*NUM_BOX-1]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:4*NUM_BOX-1]   out_data
`ifdef DES_SBOX_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [15:0]            xfer_count
`endif
);

    localparam int DW = 4 * NUM_BOX;

    if (FIRST_BOX < 1 || FIRST_BOX > 8 || NUM_BOX < 1 || NUM_BOX > 8 ||
        FIRST_BOX + NUM_BOX - 1 > 8 || PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_param
        $error("des_sbox_bank: illegal FIRST_BOX/NUM_BOX/PIPE_DEPTH combination");
    end

    // Tables are row-major, 16 nibbles per row, entry 0 in the top nibble.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] x);
        logic [255:0] tab;
        logic [5:0]   idx;
        case (box)
            1: tab = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
            2: tab = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
            3: tab = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
            4: tab = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
            5: tab = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
            6: tab = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
            7: tab = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
            8: tab = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
            default: tab = '0;
        endcase
        // x[5] is DES bit 1: row = {b0,b5}, column = b1..b4
        idx = {x[5], x[0], x[4:1]};
        return tab[{6'd63 - idx, 2'b00} +: 4];
    endfunction

    logic [0:DW-1] lut;

    for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
        assign lut[4*i +: 4] = sbox_lookup(FIRST_BOX + i, in_data[6*i +: 6]);
    end

    logic [PIPE_DEPTH:1] vld;
    logic [PIPE_DEPTH:1] load;
    logic [0:DW-1]       dat [1:PIPE_DEPTH];

    // Ready ripples back from out_ready: a stage may load if empty or if it drains this cycle.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = out_ready;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            load[k] = !vld[k] || nxt;
            nxt     = load[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                dat[k] <= '0;
            end
        end else begin
            if (load[1]) begin
                vld[1] <= in_valid;
                if (in_valid) begin
                    dat[1] <= lut;
                end
            end
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        dat[k] <= dat[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = load[1];
    assign out_valid = vld[PIPE_DEPTH];
    assign out_data  = dat[PIPE_DEPTH];

`ifdef DES_SBOX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (stats_clr) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_des_sbox_bank.sv
// tb/tb_des_sbox_bank.sv - directed-vector bench for des_sbox_bank (three parameter sets)
module tb_des_sbox_bank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [0:47] d_in_data;
    logic [0:31] d_out_data;
    logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready;
    logic [0:5]  s4_in_data;
    logic [0:3]  s4_out_data;
    logic        p2_in_valid, p2_in_ready, p2_out_valid, p2_out_ready;
    logic [0:47] p2_in_data;
    logic [0:31] p2_out_data;
`ifdef DES_SBOX_STATS_EN
    logic        d_stats_clr, s4_stats_clr, p2_stats_clr;
    logic [15:0] d_xfer_count, s4_xfer_count, p2_xfer_count;
`endif

    des_sbox_bank u_def (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data)
`ifdef DES_SBOX_STATS_EN
        , .stats_clr(d_stats_clr), .xfer_count(d_xfer_count)
`endif
    );

    des_sbox_bank #(.FIRST_BOX(4), .NUM_BOX(1), .PIPE_DEPTH(3)) u_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data)
`ifdef DES_SBOX_STATS_EN
        , .stats_clr(s4_stats_clr), .xfer_count(s4_xfer_count)
`endif
    );

    des_sbox_bank #(.PIPE_DEPTH(2)) u_p2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p2_in_valid), .in_ready(p2_in_ready), .in_data(p2_in_data),
        .out_valid(p2_out_valid), .out_ready(p2_out_ready), .out_data(p2_out_data)
`ifdef DES_SBOX_STATS_EN
        , .stats_clr(p2_stats_clr), .xfer_count(p2_xfer_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // S4 in row-major order, from the published table
    int s4_tab [0:63] = '{
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14};

    // Uniform-chunk words: every 6-bit chunk equal, so each nibble is one table entry.
    logic [47:0] words [0:4] = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'h041041041041,
                                 48'h082082082082, 48'h820820820820};
    logic [31:0] expv  [0:4] = '{32'hEFA72C4D, 32'hD9CE3DCB, 32'h03DDEAD1,
                                 32'h410DC1B2, 32'h40DA4917};

    initial begin
        rst_n = 1'b0;
        d_in_valid = 0; d_out_ready = 0; d_in_data = '0;
        s4_in_valid = 0; s4_out_ready = 0; s4_in_data = '0;
        p2_in_valid = 0; p2_out_ready = 0; p2_in_data = '0;
`ifdef DES_SBOX_STATS_EN
        d_stats_clr = 0; s4_stats_clr = 0; p2_stats_clr = 0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", d_out_valid, 0);
        check("rst_out_data", d_out_data, 0);
        check("rst_in_ready", d_in_ready, 1);
        check("rst_s4_out_valid", s4_out_valid, 0);
        check("rst_p2_in_ready", p2_in_ready, 1);
`ifdef DES_SBOX_STATS_EN
        check("rst_xfer_count", d_xfer_count, 0);
`endif

        // Single words through the default bank, one-cycle valid pulse
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            d_in_valid = 1; d_in_data = words[w]; d_out_ready = 1;
            @(negedge clk);
            check($sformatf("def_valid_%0d", w), d_out_valid, 1);
            check($sformatf("def_data_%0d", w), d_out_data, expv[w]);
            d_in_valid = 0;
            @(negedge clk);
            check($sformatf("def_pulse_%0d", w), d_out_valid, 0);
        end

        // S4-only bank, depth 3: back-to-back sweep of all 64 inputs
        begin
            int nout;
            logic [5:0] v;
            nout = 0;
            s4_out_ready = 1;
            for (int c = 0; c < 72; c++) begin
                s4_in_valid = (c < 64);
                s4_in_data  = 6'(c);
                @(negedge clk);
                if (s4_out_valid) begin
                    v = 6'(nout);
                    check($sformatf("s4_val_%0d", nout), s4_out_data, s4_tab[{v[5], v[0], v[4:1]}]);
                    check($sformatf("s4_slot_%0d", nout), c, nout + 2);
                    nout++;
                end
            end
            s4_in_valid = 0;
            check("s4_count", nout, 64);
        end

        // Depth 2 with a four-cycle output stall mid-stream
        begin
            int sent, recv, c;
            logic [31:0] held;
            logic hold_pend, saw_full;
            sent = 0; recv = 0; c = 0; hold_pend = 0; saw_full = 0; held = '0;
            while (recv < 5 && c < 40) begin
                p2_out_ready = !(c >= 2 && c <= 5);
                p2_in_valid  = (sent < 5);
                p2_in_data   = words[(sent < 5) ? sent : 0];
                #1;
                if (hold_pend) begin
                    check("p2_hold_valid", p2_out_valid, 1);
                    check("p2_hold_data", p2_out_data, held);
                end
                check($sformatf("p2_in_ready_c%0d", c), p2_in_ready,
                      ((sent - recv) < 2) || p2_out_ready);
                if (!p2_in_ready) saw_full = 1;
                hold_pend = p2_out_valid && !p2_out_ready;
                held      = p2_out_data;
                if (p2_out_valid && p2_out_ready) begin
                    if (recv < 5) check($sformatf("p2_order_%0d", recv), p2_out_data, expv[recv]);
                    recv++;
                end
                if (p2_in_valid && p2_in_ready) sent++;
                @(negedge clk);
                c++;
            end
            p2_in_valid = 0;
            check("p2_recv", recv, 5);
            check("p2_sent", sent, 5);
            check("p2_saw_full", saw_full, 1);
            @(negedge clk);
            check("p2_drained", p2_out_valid, 0);
        end

        // Asynchronous reset with two words in flight
        p2_out_ready = 0;
        p2_in_valid = 1; p2_in_data = words[1];
        @(negedge clk);
        p2_in_data = words[2];
        @(negedge clk);
        p2_in_valid = 0;
        #1;
        check("pre_rst_valid", p2_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", p2_out_valid, 0);
        check("arst_data", p2_out_data, 0);
        check("arst_in_ready", p2_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        p2_out_ready = 1;
        #1;
        check("post_rst_in_ready", p2_in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", c), p2_out_valid, 0);
        end

`ifdef DES_SBOX_STATS_EN
        begin
            int n, guard;
            check("xc_after_rst", d_xfer_count, 0);
            n = 0; guard = 0;
            d_in_valid = 1; d_in_data = words[0]; d_out_ready = 1;
            while (n < 65537 && guard < 70000) begin
                #1;
                if (d_out_valid && d_out_ready) n++;
                @(negedge clk);
                guard++;
            end
            d_in_valid = 0; d_out_ready = 0;
            check("xc_transfers", n, 65537);
            #1;
            check("xc_wrap", d_xfer_count, 1);
            d_out_ready = 1; d_stats_clr = 1;
            @(negedge clk);
            d_stats_clr = 0; d_out_ready = 0;
            #1;
            check("xc_clr_wins", d_xfer_count, 0);
            check("xc_clr_drained", d_out_valid, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_sbox_bank.md
# des_sbox_bank

Parametrised, pipelined DES substitution stage: applies a contiguous range of the eight DES S-boxes (S1..S8) to a 6-bit-per-box input word and emits the 4-bit-per-box result through a valid/ready pipeline of configurable depth. It sits in the round datapath between the expansion/key-XOR stage and the P-permutation. It replaces per-box combinational lookups with one registered, back-pressurable unit.

## Interface
- `FIRST_BOX`, default 1: index of the lowest S-box implemented, 1..8.
- `NUM_BOX`, default 8: number of consecutive S-boxes, 1..8; `FIRST_BOX+NUM_BOX-1 <= 8`.
- `PIPE_DEPTH`, default 1: register stages after the lookup, 1..4.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word present.
- `in_ready` out 1: stage accepts input this cycle.
- `in_data` in `[0:6*NUM_BOX-1]`: bits `[6i:6i+5]` feed S-box `FIRST_BOX+i`, bit 0 = DES bit 1 (MSB-first numbering).
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts.
- `out_data` out `[0:4*NUM_BOX-1]`: nibble `[4i:4i+3]` from S-box `FIRST_BOX+i`, bit `4i` = MSB.
- `stats_clr` in 1: synchronous clear of `xfer_count` (only with `DES_SBOX_STATS_EN`).
- `xfer_count` out 16: completed output transfers (only with `DES_SBOX_STATS_EN`).

## Operation
- Per box, 6-bit chunk b0..b5: row = {b0,b5}, column = {b1,b2,b3,b4}; output = FIPS 46-3 table entry for that box, row, column. All 8 standard tables are built in; the parameters select which ones are instantiated.
- Lookup is combinational on `in_data`. The result is captured into stage 1. Stages 2..`PIPE_DEPTH` are plain data+valid registers.
- Each stage k holds `vld[k]` and `dat[k]`. A stage loads when it is empty or when its contents move on in the same cycle (last stage moves on when `out_ready=1`).
- `in_ready = !vld[1] || stage 1 moves on`. The ready chain is combinational from `out_ready` back to `in_ready`; no skid buffer.
- `out_valid = vld[PIPE_DEPTH]`, `out_data = dat[PIPE_DEPTH]`.
- Transfer rules:
  - A transfer occurs only on `valid && ready` at an edge.
  - `out_data` holds stable while `out_valid=1 && out_ready=0`.
  - Bubbles between stages are compressed: an empty stage always loads.
- Reset (async, any time, including mid-stream): all `vld` cleared, `dat` cleared to 0, in-flight words are discarded. Outputs after reset: `out_valid=0`, `out_data=0`, `in_ready=1`, `xfer_count=0`.
- Illegal parameter combinations must trip an elaboration-time error.

## Timing
- Latency: a word accepted at edge N has `out_valid=1` after edge N+`PIPE_DEPTH`-1, provided no stall occurs.
- Throughput: one word per cycle while `out_ready=1`.
- Full condition: all stages valid and `out_ready=0` → `in_ready=0` in that cycle.
- Simultaneous output transfer and input acceptance with a full pipe is legal; occupancy stays unchanged.
- `out_ready` may toggle while `out_valid=0`; there is no effect.

## Configuration
- `DES_SBOX_STATS_EN` defined:
  - `xfer_count` increments on each `out_valid && out_ready` edge and wraps 0xFFFF→0x0000.
  - `stats_clr=1` sets it to 0. Clear wins over a simultaneous transfer.
  - Reset value is 0.
- Not defined: `stats_clr` and `xfer_count` ports and the counter logic are absent. The datapath is identical.

## Test plan
- Defaults, `in_data`=48'h000000000000, `out_ready=1` → after 1 cycle `out_data`=32'hEFA72C4D, `out_valid=1` for exactly one cycle.
- Defaults, `in_data`=48'hFFFFFFFFFFFF → `out_data`=32'hD9CE3DCB.
- `FIRST_BOX=4`, `NUM_BOX=1`, `PIPE_DEPTH=3`: sweep `in_data` 0..63 back-to-back, `out_ready=1`:
  - outputs begin 2 cycles after first acceptance, one per cycle.
  - values 7,13,13,8,14,... up to 63→14 match S4.
- `PIPE_DEPTH=2`, stream 5 words with `out_ready=0` for 4 cycles mid-stream:
  - `in_ready` drops once 2 words are held.
  - `out_data` stays stable during the stall.
  - no word is lost or duplicated; order is preserved.
- Assert `rst_n=0` asynchronously with 2 words in flight → `out_valid` and `out_data` go to 0 immediately. After release, `in_ready=1` and no stale word emerges.
- With `DES_SBOX_STATS_EN`:
  - 65537 transfers → `xfer_count`=1.
  - `stats_clr` coincident with a transfer → `xfer_count`=0.
